regfile_writeback: RTL

- Writeback stage that owns the single write port of the processor's 32x32 register file.
- Merges ALU results (single-cycle) and load-return data (variable latency, buffered in a small FIFO) into one registered write stream.
- Keeps a pending-load scoreboard so decode can stall on registers with an outstanding load.

---
 rtl/regfile_writeback.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: owns the single write port of the 32x32 register file.
// ALU results (single cycle) and load returns (buffered in a FIFO) share one
// registered write stream. A pending-load scoreboard lets decode stall on
// registers whose load has not yet been written back.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alu_valid_i/alu_ready_o       ALU result handshake, alu_rd_i/alu_data_i payload
//   mem_valid_i/mem_ready_o       load return handshake, mem_rd_i/mem_data_i payload
//   issue_en_i/issue_rd_i         load issue, marks issue_rd_i pending
//   rs1/rs2_addr_i, rs1/rs2_busy_o scoreboard lookup for decode
//   wr_en_o/rd_addr_o/data_o      registered register file write port
//   fifo_count_o                  load buffer occupancy
module regfile_writeback #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 alu_valid_i,
    output logic                                 alu_ready_o,
    input  logic [4:0]                           alu_rd_i,
    input  logic [31:0]                          alu_data_i,
    input  logic                                 mem_valid_i,
    output logic                                 mem_ready_o,
    input  logic [4:0]                           mem_rd_i,
    input  logic [31:0]                          mem_data_i,
    input  logic                                 issue_en_i,
    input  logic [4:0]                           issue_rd_i,
    input  logic [4:0]                           rs1_addr_i,
    input  logic [4:0]                           rs2_addr_i,
    output logic                                 rs1_busy_o,
    output logic                                 rs2_busy_o,
    output logic                                 wr_en_o,
    output logic [4:0]                           rd_addr_o,
    output logic [31:0]                          data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    rd_mem   [FIFO_DEPTH];
    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   data_q, data_d;

    logic fifo_empty, fifo_full;
    logic push, pop, alu_win;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign head_rd    = rd_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];

    // ALU is held off only while a queued load has already lost too many times.
    assign alu_ready_o = !(!fifo_empty && starve_q == SW'(STARVE_LIMIT));
    assign mem_ready_o = !fifo_full;
    assign alu_win     = alu_valid_i && alu_ready_o;
    assign pop         = !alu_win && !fifo_empty;
    // Push depends only on current occupancy, so a full FIFO refuses even when popping.
    assign push        = mem_valid_i && mem_ready_o;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        pending_d = pending_q;
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        data_d    = data_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (alu_win && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end

        if (alu_win) begin
            wr_en_d   = (alu_rd_i != 5'd0);
            rd_addr_d = alu_rd_i;
            data_d    = alu_data_i;
        end else if (pop) begin
            wr_en_d   = (head_rd != 5'd0);
            rd_addr_d = head_rd;
            data_d    = head_data;
        end

        // Clear first so a same-cycle issue to the same register wins.
        if (pop) pending_d[head_rd] = 1'b0;
        if (issue_en_i) pending_d[issue_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            data_q    <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= mem_rd_i;
            data_mem[wr_ptr_q] <= mem_data_i;
        end
    end

    assign rs1_busy_o   = pending_q[rs1_addr_i];
    assign rs2_busy_o   = pending_q[rs2_addr_i];
    assign wr_en_o      = wr_en_q;
    assign rd_addr_o    = rd_addr_q;
    assign data_o       = data_q;
    assign fifo_count_o = count_q;

endmodule
